// File: rtl/spi_peri_tx_if.sv
// spi_peri_tx_if -- byte-stream side of the SPI peripheral transmitter.
//
// Handshake: tx_dat is transferred on a rising clk edge where
// tx_valid && tx_ready are both high. The producer may raise tx_valid at any
// time and must hold tx_dat stable while tx_valid is high and tx_ready is low.
// tx_ready depends only on internal state, never on tx_valid.
//
// Signals:
//   tx_dat   [7:0]  byte offered for transmission     (producer -> peripheral)
//   tx_valid        tx_dat is valid                    (producer -> peripheral)
//   tx_ready        holding buffer is empty            (peripheral -> producer)
//   tx_done         one-clk pulse, byte fully shifted  (peripheral -> producer)
//   underrun        one-clk pulse, empty buffer loaded (peripheral -> producer)
interface spi_peri_tx_if;
  logic [7:0] tx_dat;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       underrun;

  modport master (
    output tx_dat,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  underrun
  );

  modport slave (
    input  tx_dat,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output underrun
  );
endinterface

// File: rtl/spi_peri_tx.sv
// spi_peri_tx -- SPI peripheral (slave) transmit path with a one-byte holding
// buffer. sclk and cs are synchronized into the clk domain; all edge decisions
// are made on the synchronized copies. Supports all four SPI modes, latched
// from `mode` at each synchronized cs falling edge. Consecutive bytes are sent
// without a gap while cs stays low.
//
// Build option: define SPI_PERI_TX_LSB_FIRST_EN to shift bit 0 first;
// by default bit 7 is shifted first.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sclk, cs        SPI master clock and active-low select (async to clk)
//   mode[1:0]       {cpol, cpha}
//   miso, miso_oe   serial data out and its output enable
//   fsm_state[1:0]  current FSM state (0 IDLE, 1 SHIFT, 2 DONE) for debug
//   tx              byte-stream interface (slave modport)
module spi_peri_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sclk,
  input  logic           cs,
  input  logic [1:0]     mode,
  output logic           miso,
  output logic           miso_oe,
  output logic [1:0]     fsm_state,
  spi_peri_tx_if.slave   tx
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] FLUSH_N = 2'(SYNC_STAGES);

  function automatic logic first_bit(input logic [7:0] d);
`ifdef SPI_PERI_TX_LSB_FIRST_EN
    return d[0];
`else
    return d[7];
`endif
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] d);
`ifdef SPI_PERI_TX_LSB_FIRST_EN
    return {1'b0, d[7:1]};
`else
    return {d[6:0], 1'b0};
`endif
  endfunction

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic       sclk_s, cs_s, sclk_prev, cs_prev;
  logic [1:0] flush_cnt;
  logic       armed;
  logic       cpol_q, cpha_q;
  logic       buf_full;
  logic [7:0] buf_dat, sr;
  logic       miso_q;
  logic [2:0] bit_cnt;

  logic cs_fall, lead_edge, trail_edge, sample_edge, drive_edge;
  logic load, ld_cpha, tx_done_c, underrun_c;
  logic [7:0] ld_byte;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // Synchronizers idle at cs=1/sclk=0. After reset the pipeline still holds
  // those idle values, so a cs pin held low through reset would look like a
  // falling edge once it flushes. `armed` only goes high after the pipeline
  // has flushed and cs is seen high, so a start always needs a real cs fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      flush_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      if (flush_cnt != FLUSH_N) flush_cnt <= flush_cnt + 2'd1;
      else if (cs_s)            armed     <= 1'b1;
    end
  end

  assign cs_fall     = armed && cs_prev && !cs_s;
  assign lead_edge   = (sclk_prev == cpol_q) && (sclk_s != cpol_q);
  assign trail_edge  = (sclk_prev != cpol_q) && (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge  : trail_edge;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Completion of the 8th bit wins over a simultaneous cs
  // rise so a master that releases cs on its last sampling edge still gets
  // tx_done (and no extra reload).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT: begin
        if (sample_edge && bit_cnt == 3'd7) state_nxt = DONE;
        else if (cs_s)                      state_nxt = IDLE;
      end
      DONE:    state_nxt = cs_s ? IDLE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load       = (state == IDLE && cs_fall) || (state == DONE && !cs_s);
    tx_done_c  = (state == DONE);
    underrun_c = load && !buf_full;
  end

  // On a fresh start the mode is being latched this same cycle.
  assign ld_cpha = (state == IDLE) ? mode[0] : cpha_q;
  assign ld_byte = buf_full ? buf_dat : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      buf_full <= 1'b0;
      buf_dat  <= 8'h00;
      sr       <= 8'h00;
      miso_q   <= 1'b0;
      bit_cnt  <= 3'd0;
    end else begin
      if (state == IDLE && cs_fall) {cpol_q, cpha_q} <= mode;

      // A load sees the pre-write buffer; writes are only accepted while the
      // buffer is empty, so the two never fight over buf_full.
      if (load && buf_full) buf_full <= 1'b0;
      if (tx.tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_dat  <= tx.tx_dat;
      end

      if (load) begin
        bit_cnt <= 3'd0;
        if (ld_cpha) begin
          sr     <= ld_byte;
          miso_q <= 1'b0;
        end else begin
          sr     <= shift_out(ld_byte);
          miso_q <= first_bit(ld_byte);
        end
      end else if (state == SHIFT) begin
        if (sample_edge) bit_cnt <= bit_cnt + 3'd1;
        // cpha=0: the trailing edge that follows a reload belongs to the
        // previous byte, so no shifting until this byte's first sample.
        if (drive_edge && (cpha_q || bit_cnt != 3'd0)) begin
          miso_q <= first_bit(sr);
          sr     <= shift_out(sr);
        end
      end else if (state == IDLE) begin
        bit_cnt <= 3'd0;
        miso_q  <= 1'b0;
      end
    end
  end

  assign miso        = cs_s ? 1'b0 : miso_q;
  assign miso_oe     = !cs_s;
  assign fsm_state   = state;
  assign tx.tx_ready = !buf_full;
  assign tx.tx_done  = tx_done_c;
  assign tx.underrun = underrun_c;

endmodule

// File: doc/spi_peri_tx.md
SPI_PERI_TX -- requirements
Module: spi_peri_tx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk and cs; legal values 2..3.
REQ-002 clk  input  1: single system clock; all state updates on its rising edge; at least 4x the sclk frequency.
REQ-003 rst  input  1: reset, synchronous and active-high.
REQ-004 sclk  input  1: serial clock from the SPI master; asynchronous to clk.
REQ-005 cs  input  1: chip select from the master, active-low; asynchronous to clk.
REQ-006 mode  input  2: {cpol, cpha}; sampled at each synchronized cs falling edge and held for that transaction.
REQ-007 tx_dat  input  8: byte offered for transmission.
REQ-008 tx_valid  input  1: tx_dat is valid.
REQ-009 tx_ready  output  1: holding buffer is empty; a write occurs when tx_valid && tx_ready.
REQ-010 miso  output  1: serial data to the master.
REQ-011 miso_oe  output  1: miso output enable; high only while the synchronized cs is low.
REQ-012 tx_done  output  1: one-clk pulse when all 8 bits of a byte have completed.
REQ-013 underrun  output  1: one-clk pulse when a byte is loaded while the holding buffer is empty.

Function
REQ-014 sclk and cs each pass through a SYNC_STAGES flip-flop synchronizer; edges are detected on the synchronized values only.
REQ-015 Leading edge = sclk transition away from cpol; trailing edge = transition back to cpol.
REQ-016 FSM states: IDLE, SHIFT, DONE.
REQ-017 IDLE -> SHIFT on cs falling edge: shift register loads the holding buffer, which is then emptied; if the buffer is empty, it loads 8'h00 and pulses underrun.
REQ-018 MSB first by default; bit counter 0..7 counts the master's sampling edges (leading when cpha=0, trailing when cpha=1).
REQ-019 cpha=0: bit 7 is on miso in the same cycle the load occurs; each later bit shifts out on a trailing edge.
REQ-020 cpha=1: each bit, bit 7 first, is driven on a leading edge; the value before the first leading edge is 0.
REQ-021 On the 8th sampling edge: SHIFT -> DONE and tx_done pulses.
REQ-022 DONE with cs still low -> SHIFT in the next cycle; the load and underrun rules of REQ-017 apply (back-to-back bytes, no gap).
REQ-023 DONE with cs high -> IDLE.
REQ-024 cs rising edge in SHIFT (abort): -> IDLE next cycle; no tx_done; the partial byte is discarded; the holding buffer is unaffected.
REQ-025 A buffer write and a load in the same cycle: the load uses the pre-write buffer content (empty -> 8'h00 and underrun); the written byte is retained for the next load.
REQ-026 tx_ready is low while the buffer is full; it rises the cycle after a load consumes the buffer.
REQ-027 While cs is high, miso = 0 and miso_oe = 0.
REQ-028 Master sclk edges while cs is high are ignored; sclk activity in IDLE does not change state.

Reset
REQ-029 On rst: state = IDLE, buffer empty, tx_ready = 1, miso = 0, miso_oe = 0, tx_done = 0, underrun = 0, bit counter = 0, shift register = 0, synchronizers = idle values (cs = 1, sclk = 0).
REQ-030 rst asserted mid-byte: the transfer is abandoned without tx_done; a new transfer requires a fresh cs falling edge after rst is released.

Configuration
REQ-031 Macro SPI_PERI_TX_LSB_FIRST_EN defined: bits are shifted out LSB first (bit 0 first).
REQ-032 Macro SPI_PERI_TX_LSB_FIRST_EN undefined: bits are shifted out MSB first; all other behaviour is identical in both builds.

Verification
REQ-033 Mode 0: write 8'hA5, then an 8-clock master transfer -> master samples 10100101; one tx_done pulse; tx_ready = 1 afterwards.
REQ-034 Mode 3: write 8'h3C, then transfer -> master samples 00111100; no underrun.
REQ-035 Modes 1 and 2: back-to-back 8'h81 then 8'h7E with cs held low for 16 clocks -> master receives both bytes in order; two tx_done pulses; no underrun.
REQ-036 Empty buffer, mode 0 transfer -> master receives 8'h00; one underrun pulse at the cs fall; tx_done still pulses.
REQ-037 cs raised after 4 bits of 8'hF0 -> no tx_done; miso_oe = 0; the next transfer uses a new buffer write (8'h55 -> 01010101).
REQ-038 SPI_PERI_TX_LSB_FIRST_EN build, mode 0, 8'h01 -> master receives 10000000.
